// File: rtl/fb_port_arbiter.sv
// ============================================================================
// fb_port_arbiter : single-port frame-buffer arbiter (display > clear > FIFO)
// Rev 1.0
// ============================================================================
`default_nettype none

module fb_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 255
) (
    input  logic                            clk10,
    input  logic                            rst,
    input  logic                            disp_req,
    input  logic [ADDR_W-1:0]               disp_addr,
    output logic                            disp_valid,
    output logic [DATA_W-1:0]               disp_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            clr_start,
    input  logic [DATA_W-1:0]               clr_value,
    output logic                            clr_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            starve,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_we,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0]  STV_MAX   = STV_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   clr_val_q, clr_val_d;
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          rd_pend_q;
    logic                disp_valid_q;
    logic [DATA_W-1:0]   disp_data_q;
    logic                push, pop;

    assign wr_ready   = (level_q != FULL_LVL);
    assign push       = wr_valid && wr_ready;
    assign fifo_level = level_q;
    assign clr_busy   = (state_q == ST_CLEAR);
    assign starve     = (starve_cnt_q == STV_MAX);
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_val_d    = clr_val_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        pop          = 1'b0;
        level_d      = level_q;
        starve_cnt_d = starve_cnt_q;

        // Slot priority: display read, then clear fill, then FIFO drain.
        if (disp_req) begin
            mem_addr_d = disp_addr;
        end else if (state_q == ST_CLEAR) begin
            mem_addr_d  = clr_cnt_q;
            mem_we_d    = 1'b1;
            mem_wdata_d = clr_val_q;
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = ST_IDLE;
            end
        end else if (level_q != '0) begin
            pop         = 1'b1;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_we_d    = 1'b1;
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end

        if ((state_q == ST_IDLE) && clr_start) begin
            state_d   = ST_CLEAR;
            clr_val_d = clr_value;
            clr_cnt_d = '0;
        end

        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if ((level_q == '0) || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STV_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk10 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            clr_val_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_pend_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_val_q    <= clr_val_d;
            level_q      <= level_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Stage 0: RAM addressed; stage 1: mem_rdata valid, captured here.
            rd_pend_q    <= {rd_pend_q[0], disp_req};
            disp_valid_q <= rd_pend_q[1];
            if (rd_pend_q[1]) begin
                disp_data_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk10) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port 64x32 x 2-bit frame-buffer RAM between two users:
  - the composite scan-out reader, which is latency-critical and has absolute priority;
  - a host write path (loader or drawing engine), buffered through a small write FIFO.
- Also sequences a hardware frame clear that fills every location with a constant using only idle RAM cycles.
- Sits between the composite timing/pixel logic and the frame-buffer RAM instance.

Parameters:
- ADDR_W, 11, frame-buffer address width (2048 entries = 64x32).
- DATA_W, 2, pixel width.
- FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.
- STARVE_MAX, 255, consecutive display-held cycles with FIFO non-empty before starve asserts.

Ports:
- clk10  in  1  pixel/sample clock.
- rst  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request, sampled every cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  disp_data valid strobe.
- disp_data  out  DATA_W  display read data.
- wr_valid  in  1  host write valid.
- wr_ready  out  1  host write ready.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  DATA_W  host write data.
- clr_start  in  1  one-cycle pulse that starts a full clear.
- clr_value  in  DATA_W  fill value, captured at clr_start.
- clr_busy  out  1  clear in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- starve  out  1  write path starved.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (mem_addr, mem_we, mem_wdata, disp_valid, disp_data, clr_busy, starve, fifo_level). FIFO emptied, state IDLE, clear counter 0, starve counter 0. wr_ready is 1 in the first cycle after release.
- Slot decision in cycle N uses inputs sampled at N. The chosen access appears on mem_* in N+1. Priority, highest first:
  1. disp_req: read, mem_we=0, mem_addr=disp_addr.
  2. CLEAR state: write clr_value at the clear counter address.
  3. IDLE with FIFO non-empty: pop the FIFO head and write it.
  4. Otherwise: mem_we=0, mem_addr holds its last value.
- Display read latency:
  - disp_req at N; RAM addressed at N+1; mem_rdata valid at N+2.
  - disp_data registered, disp_valid=1 in N+3, exactly 3 cycles after the request.
  - Back-to-back requests give back-to-back valids.
  - A display request is never delayed or dropped.
- Write FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = !full, from registered occupancy. When full, wr_ready stays 0 even in a pop cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Entries are written to RAM in push order.
- FSM:
  - IDLE -> CLEAR on clr_start: capture clr_value, counter=0, clr_busy=1 from the next cycle.
  - CLEAR: each non-display cycle writes address=counter, then counter+1. The write of address 2047 returns the FSM to IDLE; clr_busy falls the cycle after that write issues. Counter wraps to 0.
  - The FIFO is not drained during CLEAR but keeps accepting pushes until full.
  - clr_start during CLEAR is ignored.
  - clr_start while disp_req is high: the transition still happens; the first clear write waits for a free slot.
- Starve counter:
  - Counts cycles where the FIFO is non-empty and no FIFO pop occurs (display or clear holding the port).
  - Clears to 0 on any pop or when the FIFO is empty. Saturates at STARVE_MAX.
  - starve=1 while the count equals STARVE_MAX.
- Reset mid-clear or with a non-empty FIFO: clear aborted, queued writes discarded. The RAM write in flight during the reset cycle is not guaranteed.
- Widths: all address arithmetic is modulo 2^ADDR_W. fifo_level ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then disp_req=1 with disp_addr=5 (RAM[5]=2'b10) at cycle N -> mem_addr=5, mem_we=0 at N+1; disp_valid=1, disp_data=2'b10 at N+3; no other valid pulses.
- Push 4 writes (addr 10..13, data 1,2,3,0) with disp_req held high -> wr_ready=0 after the 4th push, fifo_level=4. Drop disp_req -> 4 consecutive mem_we pulses to 10,11,12,13 in order; fifo_level returns to 0 and wr_ready returns to 1.
- clr_start with clr_value=2'b11 and disp_req asserted every 8th cycle -> exactly 2048 mem_we writes of 11 covering 0..2047 once each. Every display request is served with 3-cycle latency. clr_busy deasserts after the address-2047 write.
- Push 2 writes during CLEAR -> neither is written until clr_busy falls, then both are written in order. A second clr_start mid-clear has no effect (total clear writes still 2048).
- FIFO non-empty with disp_req held high for 300 cycles -> starve=1 from the 256th held cycle. Release disp_req -> pop occurs, starve=0 the following cycle.
- Assert rst for 1 cycle mid-clear with fifo_level=3 -> clr_busy=0, fifo_level=0, mem_we=0 immediately. No further writes until new traffic.
